nios_fast_div_cell: RTL and testbench

//  Iterative radix-2 restoring divider: the inverse companion of the CPU's fast multiply cell.

---
 rtl/nios_div_pkg.sv | 16 +
 rtl/nios_fast_div_cell_if.sv | 27 ++
 rtl/nios_div_step.sv | 22 ++
 rtl/nios_fast_div_cell.sv | 131 +++++++++++++
 tb/tb_nios_fast_div_cell.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/nios_div_pkg.sv
// Shared types and constants for the iterative divide cell.
package nios_div_pkg;

  localparam int unsigned DIV_W_DEF = 32;

  localparam logic [DIV_W_DEF-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/nios_fast_div_cell_if.sv
// Start/busy/done handshake and operand/result bus of the divide cell.
interface nios_fast_div_cell_if
  import nios_div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) ();

  logic             A_div_start;
  logic             A_div_signed;
  logic [DIV_W-1:0] A_div_src1;
  logic [DIV_W-1:0] A_div_src2;
  logic             A_div_busy;
  logic             A_div_done;
  logic [DIV_W-1:0] A_div_quotient;
  logic [DIV_W-1:0] A_div_remainder;

  modport master (
    output A_div_start, A_div_signed, A_div_src1, A_div_src2,
    input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder
  );

  modport slave (
    input  A_div_start, A_div_signed, A_div_src1, A_div_src2,
    output A_div_busy, A_div_done, A_div_quotient, A_div_remainder
  );

endinterface

// File: rtl/nios_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module nios_div_step #(
  parameter int unsigned DIV_W = 32
) (
  input  logic [DIV_W-1:0] rem_in,
  input  logic [DIV_W-1:0] q_in,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic [DIV_W-1:0] q_out
);

  logic [DIV_W:0] trial;
  logic           fits;

  always_comb begin
    trial   = {rem_in, q_in[DIV_W-1]};
    fits    = (trial >= {1'b0, divisor});
    rem_out = fits ? DIV_W'(trial - {1'b0, divisor}) : trial[DIV_W-1:0];
    q_out   = {q_in[DIV_W-2:0], fits};
  end

endmodule

// File: rtl/nios_fast_div_cell.sv
// Iterative radix-2 restoring divider, fixed DIV_W+4 cycle latency.
// Define NIOS_DIV_SIGNED_EN to honour A_div_signed; otherwise every operation is unsigned.
module nios_fast_div_cell
  import nios_div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  nios_fast_div_cell_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DIV_W);

  div_state_t       state, state_nxt;
  logic             busy_nxt, done_nxt;

  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] op_a, op_b;
  logic             sgn;
  logic [DIV_W-1:0] rem, quo, div;
  logic             q_neg, r_neg, div0;
  logic [DIV_W-1:0] step_rem, step_q;

  logic             busy, done;
  logic [DIV_W-1:0] quotient, remainder;

  nios_div_step #(.DIV_W(DIV_W)) u_step (
    .rem_in  (rem),
    .q_in    (quo),
    .divisor (div),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and registered-output enables
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    case (state)
      IDLE:    if (bus.A_div_start) state_nxt = PREP;
      PREP:    state_nxt = ITER;
      ITER:    if (cnt == CNT_W'(0)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    begin
                 state_nxt = IDLE;
                 done_nxt  = 1'b1;
               end
      default: state_nxt = IDLE;
    endcase
    // Busy spans the done pulse; a start in that cycle keeps it high.
    busy_nxt = (state_nxt != IDLE) || done_nxt;
  end

  // Datapath; quo doubles as the dividend shift register during ITER
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      sgn       <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      div       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div0      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      case (state)
        IDLE: begin
          if (bus.A_div_start) begin
            op_a <= bus.A_div_src1;
            op_b <= bus.A_div_src2;
`ifdef NIOS_DIV_SIGNED_EN
            sgn  <= bus.A_div_signed;
`else
            sgn  <= 1'b0;
`endif
          end
        end
        PREP: begin
          quo   <= (sgn && op_a[DIV_W-1]) ? (~op_a + DIV_W'(1)) : op_a;
          div   <= (sgn && op_b[DIV_W-1]) ? (~op_b + DIV_W'(1)) : op_b;
          rem   <= '0;
          q_neg <= sgn && (op_a[DIV_W-1] ^ op_b[DIV_W-1]);
          r_neg <= sgn && op_a[DIV_W-1];
          div0  <= (op_b == '0);
          cnt   <= CNT_W'(DIV_W - 1);
        end
        ITER: begin
          rem <= step_rem;
          quo <= step_q;
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (div0) begin
            quo <= DIV_W'(DIV0_QUOTIENT);
            rem <= op_a;
          end else begin
            if (q_neg) quo <= ~quo + DIV_W'(1);
            if (r_neg) rem <= ~rem + DIV_W'(1);
          end
        end
        DONE: begin
          quotient  <= quo;
          remainder <= rem;
        end
        default: ;
      endcase
    end
  end

  assign bus.A_div_busy      = busy;
  assign bus.A_div_done      = done;
  assign bus.A_div_quotient  = quotient;
  assign bus.A_div_remainder = remainder;

endmodule

// File: tb/tb_nios_fast_div_cell.sv
// Directed checks of nios_fast_div_cell: latency, signed/unsigned results, div-by-zero,
// ignored starts, back-to-back issue and asynchronous reset abort.
module tb_nios_fast_div_cell;

`ifdef NIOS_DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  nios_fast_div_cell_if #(.DIV_W(32)) bus ();

  nios_fast_div_cell #(.DIV_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural reference for the random section
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    logic sm;
    sm = s & SGN;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sm) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called #1 after a rising edge with the DUT idle (or in its done cycle);
  // returns #1 after the edge that raises done (or after the timeout).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er,
                       input string tag, input int poke_at);
    int cyc, low, chg;
    logic [31:0] prev_q, prev_r;
    bus.A_div_src1   = a;
    bus.A_div_src2   = b;
    bus.A_div_signed = s;
    bus.A_div_start  = 1'b1;
    @(posedge clk); #1;
    bus.A_div_start  = 1'b0;
    bus.A_div_src1   = $urandom;
    bus.A_div_src2   = $urandom;
    bus.A_div_signed = 1'($urandom_range(0, 1));
    cyc = 0; low = 0; chg = 0;
    prev_q = bus.A_div_quotient;
    prev_r = bus.A_div_remainder;
    while (cyc < 60 && !bus.A_div_done) begin
      if (!bus.A_div_busy) low++;
      if (bus.A_div_quotient !== prev_q || bus.A_div_remainder !== prev_r) chg++;
      if (cyc == poke_at) bus.A_div_start = 1'b1;
      @(posedge clk); #1;
      bus.A_div_start = 1'b0;
      cyc++;
    end
    check_eq($sformatf("%s latency", tag), 32'(cyc), 32'd35);
    check_eq($sformatf("%s busy_gap", tag), 32'(low), 32'd0);
    check_eq($sformatf("%s held", tag), 32'(chg), 32'd0);
    check_eq($sformatf("%s busy_at_done", tag), 32'(bus.A_div_busy), 32'd1);
    check_eq($sformatf("%s quotient", tag), bus.A_div_quotient, eq);
    check_eq($sformatf("%s remainder", tag), bus.A_div_remainder, er);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      if (bus.A_div_done) n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb, rq, rr;
    logic        rs;

    reset            = 1'b1;
    bus.A_div_start  = 1'b0;
    bus.A_div_signed = 1'b0;
    bus.A_div_src1   = '0;
    bus.A_div_src2   = '0;
    #2;
    check_eq("rst busy", 32'(bus.A_div_busy), 32'd0);
    check_eq("rst done", 32'(bus.A_div_done), 32'd0);
    check_eq("rst quotient", bus.A_div_quotient, 32'd0);
    check_eq("rst remainder", bus.A_div_remainder, 32'd0);
    #20 reset = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic vectors
    do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "u100_7", -1);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1,
          SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, SGN ? 32'hFFFF_FFFF : 32'd1, "s-7_2", -1);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1,
          SGN ? 32'hFFFF_FFFD : 32'd0, SGN ? 32'd1 : 32'd7, "s7_-2", -1);
    do_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1,
          SGN ? 32'd3 : 32'd0, SGN ? 32'hFFFF_FFFF : 32'hFFFF_FFF9, "s-7_-2", -1);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, "u_neg7_2", -1);
    do_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, "u5_0", -1);
    do_op(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "s-5_0", -1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
          SGN ? 32'h8000_0000 : 32'd0, SGN ? 32'd0 : 32'h8000_0000, "s_ovf", -1);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, "u_max_1", -1);
    do_op(32'd12345, 32'd12345, 1'b0, 32'd1, 32'd0, "u_eq", -1);
    @(posedge clk); #1;
    check_eq("idle busy", 32'(bus.A_div_busy), 32'd0);
    check_eq("idle done", 32'(bus.A_div_done), 32'd0);

    // Start while busy is dropped, then back-to-back starts in the done cycle
    do_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, "poke", 10);
    @(posedge clk); #1;
    count_dones(40, n);
    check_eq("no_queue dones", 32'(n), 32'd0);
    do_op(32'd77, 32'd5, 1'b0, 32'd15, 32'd2, "b2b_a", -1);
    do_op(32'hFFFF_FFFF, 32'd10, 1'b0, 32'h1999_9999, 32'd5, "b2b_b", -1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation
    bus.A_div_src1  = 32'd50;
    bus.A_div_src2  = 32'd3;
    bus.A_div_start = 1'b1;
    @(posedge clk); #1;
    bus.A_div_start = 1'b0;
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_eq("abort busy", 32'(bus.A_div_busy), 32'd0);
    check_eq("abort done", 32'(bus.A_div_done), 32'd0);
    check_eq("abort quotient", bus.A_div_quotient, 32'd0);
    check_eq("abort remainder", bus.A_div_remainder, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    count_dones(50, n);
    check_eq("abort dones", 32'(n), 32'd0);
    do_op(32'd50, 32'd3, 1'b0, 32'd16, 32'd2, "after_rst", -1);

    // Random operands, both modes, against the reference
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(1, 15));
        1:       rb = (i % 20 == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      ref_div(ra, rb, rs, rq, rr);
      do_op(ra, rb, rs, rq, rr, $sformatf("rnd%0d", i), -1);
    end
    @(posedge clk); #1;
    check_eq("end busy", 32'(bus.A_div_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
